// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data ports.
// Adds a core stall, fixed-priority grant and a per-transaction timeout that reports a bus error.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit DATA_FIRST = 1'b1,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_request,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_request,
  input  logic                d_we_re,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_request,
  output logic                mem_we_re,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_valid,
  output logic                stall,
  output logic                bus_error
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter is checked one step early so the abort lands on the TIMEOUT-th busy cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                bus_error_q, bus_error_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic if_elig, d_elig, grant_i, grant_d, timeout_hit;

  // A port is not eligible while its own completion pulse is showing.
  assign if_elig     = if_request & ~if_valid_q;
  assign d_elig      = d_request & ~d_valid_q;
  assign grant_d     = d_elig & (DATA_FIRST | ~if_elig);
  assign grant_i     = if_elig & ~grant_d;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_error_d = 1'b0;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
          we_d    = d_we_re;
          mask_d  = d_mask;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          cnt_d   = '0;
        end else if (grant_i) begin
          state_d = BUSY_I;
          we_d    = 1'b0;
          mask_d  = '1;
          addr_d  = if_addr;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!we_q) d_rdata_d = mem_rdata;
            d_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          bus_error_d = 1'b1;
          if (state_q == BUSY_I) begin
            if_rdata_d = '0;
            if_valid_d = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      mask_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_error_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_error_q <= bus_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_request = (state_q != IDLE);
  assign mem_we_re   = we_q;
  assign mem_mask    = mask_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_valid     = d_valid_q;
  assign bus_error   = bus_error_q;
  assign stall       = if_elig | d_elig;

endmodule
